// File: rtl/ks_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: single-bit prefix cells
// and elaboration-time constants.
package ks_pkg;

    localparam int KS_MAX_LEVELS = 7;

    function automatic logic black_g(input logic g_i, input logic p_i, input logic g_j);
        return g_i | (p_i & g_j);
    endfunction

    function automatic logic black_p(input logic p_i, input logic p_j);
        return p_i & p_j;
    endfunction

    function automatic logic grey_g(input logic g_i, input logic p_i, input logic g_j);
        return g_i | (p_i & g_j);
    endfunction

    function automatic int popcount(input logic [KS_MAX_LEVELS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < KS_MAX_LEVELS; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    function automatic int level_dist(input int k);
        return 32'sd1 <<< (k - 32'sd1);
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone prefix level at distance DIST, optionally followed by a
// valid-gated pipeline register that joins the valid/ready chain.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DIST    = 1,
    parameter bit OPT_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_g,
    input  logic [WIDTH-1:0] in_p,
    input  logic [WIDTH:0]   in_aux,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_g,
    output logic [WIDTH-1:0] out_p,
    output logic [WIDTH:0]   out_aux
);

    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] p_s;

    // Node n already spans DIST bits; nodes below 2*DIST combine with a resolved prefix.
    always_comb begin
        int j;
        g_s = in_g;
        p_s = in_p;
        for (int n = 0; n < WIDTH; n++) begin
            j = (n >= DIST) ? (n - DIST) : 0;
            if (n >= 2 * DIST) begin
                g_s[n] = black_g(in_g[n], in_p[n], in_g[j]);
                p_s[n] = black_p(in_p[n], in_p[j]);
            end else if (n >= DIST) begin
                g_s[n] = grey_g(in_g[n], in_p[n], in_g[j]);
                p_s[n] = 1'b0;
            end else begin
                g_s[n] = in_g[n];
                p_s[n] = in_p[n];
            end
        end
    end

    if (OPT_REG) begin : g_reg
        logic             v_q, v_d, en_s;
        logic [WIDTH-1:0] g_q, g_d, p_q, p_d;
        logic [WIDTH:0]   aux_q, aux_d;

        // Slot loads when empty or when its occupant leaves this cycle.
        always_comb begin
            en_s  = !v_q || out_ready;
            g_d   = g_q;
            p_d   = p_q;
            aux_d = aux_q;
            if (flush) begin
                v_d = 1'b0;
            end else if (en_s) begin
                v_d = in_valid;
            end else begin
                v_d = v_q;
            end
            if (en_s && in_valid) begin
                g_d   = g_s;
                p_d   = p_s;
                aux_d = in_aux;
            end else begin
                g_d   = g_q;
                p_d   = p_q;
                aux_d = aux_q;
            end
        end

        // Stage register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                g_q   <= '0;
                p_q   <= '0;
                aux_q <= '0;
            end else begin
                v_q   <= v_d;
                g_q   <= g_d;
                p_q   <= p_d;
                aux_q <= aux_d;
            end
        end

        assign in_ready  = en_s;
        assign out_valid = v_q;
        assign out_g     = g_q;
        assign out_p     = p_q;
        assign out_aux   = aux_q;
    end else begin : g_comb
        logic unused_s;
        assign unused_s  = ^{clk, rst, flush};
        assign in_ready  = out_ready;
        assign out_valid = in_valid;
        assign out_g     = g_s;
        assign out_p     = p_s;
        assign out_aux   = in_aux;
    end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready backpressure, synchronous flush,
// carry-out and signed overflow. Registers follow the levels selected by PIPE_MASK.
module ks_adder_pipe
    import ks_pkg::*;
#(
    parameter int                WIDTH     = 32,
    parameter int                LEVELS    = $clog2(WIDTH),
    parameter logic [LEVELS-1:0] PIPE_MASK = 5'b00100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic             s0_v_q, s0_v_d, s0_en_s, s0_rdy_s, accept_s;
    logic [WIDTH-1:0] s0_g_q, s0_g_d, s0_p_q, s0_p_d;
    logic [WIDTH:0]   s0_aux_q, s0_aux_d;

    logic             out_v_q, out_v_d, out_en_s;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;

    logic             fin_v_s;
    logic [WIDTH-1:0] fin_g_s;
    logic [WIDTH:0]   fin_aux_s;
    logic             unused_fin_p_s;

    // Operand capture; cin is folded into the bit-0 generate so G[i] is the full carry out of bit i.
    always_comb begin
        s0_en_s  = !s0_v_q || s0_rdy_s;
        in_ready = s0_en_s && !flush;
        accept_s = in_valid && in_ready;
        s0_g_d   = s0_g_q;
        s0_p_d   = s0_p_q;
        s0_aux_d = s0_aux_q;
        if (flush) begin
            s0_v_d = 1'b0;
        end else if (s0_en_s) begin
            s0_v_d = accept_s;
        end else begin
            s0_v_d = s0_v_q;
        end
        if (accept_s) begin
            s0_p_d    = a ^ b;
            s0_g_d    = a & b;
            s0_g_d[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
            s0_aux_d  = {a ^ b, cin};
        end else begin
            s0_g_d   = s0_g_q;
            s0_p_d   = s0_p_q;
            s0_aux_d = s0_aux_q;
        end
    end

    // S0 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_v_q   <= 1'b0;
            s0_g_q   <= '0;
            s0_p_q   <= '0;
            s0_aux_q <= '0;
        end else begin
            s0_v_q   <= s0_v_d;
            s0_g_q   <= s0_g_d;
            s0_p_q   <= s0_p_d;
            s0_aux_q <= s0_aux_d;
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        logic             in_v_s, in_rdy_s, out_v_s, out_rdy_s;
        logic [WIDTH-1:0] in_g_s, in_p_s, out_g_s, out_p_s;
        logic [WIDTH:0]   in_aux_s, out_aux_s;

        if (k == 1) begin : g_src
            assign in_v_s   = s0_v_q;
            assign in_g_s   = s0_g_q;
            assign in_p_s   = s0_p_q;
            assign in_aux_s = s0_aux_q;
        end else begin : g_src
            assign in_v_s   = g_level[k-1].out_v_s;
            assign in_g_s   = g_level[k-1].out_g_s;
            assign in_p_s   = g_level[k-1].out_p_s;
            assign in_aux_s = g_level[k-1].out_aux_s;
        end

        if (k == LEVELS) begin : g_snk
            assign out_rdy_s = out_en_s;
        end else begin : g_snk
            assign out_rdy_s = g_level[k+1].in_rdy_s;
        end

        ks_prefix_level #(
            .WIDTH   (WIDTH),
            .DIST    (level_dist(k)),
            .OPT_REG (PIPE_MASK[k-1])
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (in_v_s),
            .in_ready  (in_rdy_s),
            .in_g      (in_g_s),
            .in_p      (in_p_s),
            .in_aux    (in_aux_s),
            .out_valid (out_v_s),
            .out_ready (out_rdy_s),
            .out_g     (out_g_s),
            .out_p     (out_p_s),
            .out_aux   (out_aux_s)
        );
    end

    assign s0_rdy_s       = g_level[1].in_rdy_s;
    assign fin_v_s        = g_level[LEVELS].out_v_s;
    assign fin_g_s        = g_level[LEVELS].out_g_s;
    assign fin_aux_s      = g_level[LEVELS].out_aux_s;
    assign unused_fin_p_s = ^g_level[LEVELS].out_p_s;

    // Result stage: carry into bit i is G[i-1] (cin for bit 0); ovf compares carries into and out of the MSB.
    always_comb begin
        out_en_s = !out_v_q || out_ready;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (flush) begin
            out_v_d = 1'b0;
        end else if (out_en_s) begin
            out_v_d = fin_v_s;
        end else begin
            out_v_d = out_v_q;
        end
        if (out_en_s && fin_v_s) begin
            sum_d  = fin_aux_s[WIDTH:1] ^ {fin_g_s[WIDTH-2:0], fin_aux_s[0]};
            cout_d = fin_g_s[WIDTH-1];
            ovf_d  = fin_g_s[WIDTH-1] ^ fin_g_s[WIDTH-2];
        end else begin
            sum_d  = sum_q;
            cout_d = cout_q;
            ovf_d  = ovf_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            out_v_q <= out_v_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = out_v_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Directed bench for ks_adder_pipe: default 32-bit build plus a 16-bit fully pipelined build.
module tb_ks_adder_pipe;
    import ks_pkg::*;

    localparam int LAT32 = 2 + popcount(7'b0000100);
    localparam int LAT16 = 2 + popcount(7'b0001111);

    logic        clk, rst, flush, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;
    logic        iv16, ir16, cin16, ov16, or16, cout16, ovf16, flush16;
    logic [15:0] a16, b16, sum16;

    int checks = 0;
    int errors = 0;
    int sent   = 0;
    int seen;
    logic [33:0] exp_q[$];
    logic [33:0] held;

    ks_adder_pipe u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    ks_adder_pipe #(.WIDTH(16), .PIPE_MASK(4'b1111)) u_dut16 (
        .clk(clk), .rst(rst), .flush(flush16), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16), .out_valid(ov16), .out_ready(or16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] t;
        t = {1'b0, x} + {1'b0, y} + {32'd0, c};
        return {(x[31] == y[31]) && (t[31] != x[31]), t[32], t[31:0]};
    endfunction

    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] t;
        t = {1'b0, x} + {1'b0, y} + {16'd0, c};
        return {(x[15] == y[15]) && (t[15] != x[15]), t[16], t[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs are already set; account handshakes just before the edge, then cross it.
    task automatic cycle_io();
        logic [33:0] e;
        #1;
        if (in_valid && in_ready) begin
            exp_q.push_back(model32(a, b, cin));
            sent++;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'(1'b1), 64'(1'b0));
            end else begin
                e = exp_q.pop_front();
                chk("stream_result", 64'({ovf, cout, sum}), 64'(e));
            end
        end
        step();
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle_io();
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic single(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, input logic [33:0] exp_v);
        int lat;
        a = av; b = bv; cin = cv; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(LAT32));
        chk(tag, 64'({ovf, cout, sum}), 64'(exp_v));
        step();
    endtask

    task automatic single16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic cv, input logic [17:0] exp_v);
        int lat;
        a16 = av; b16 = bv; cin16 = cv; iv16 = 1'b1; or16 = 1'b1;
        step();
        iv16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 16) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(LAT16));
        chk(tag, 64'({ovf16, cout16, sum16}), 64'(exp_v));
        step();
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 32'd0; b = 32'd0; cin = 1'b0;
        iv16 = 1'b0; or16 = 1'b1; cin16 = 1'b0; flush16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
        step();
        step();
        chk("reset_out_valid", 64'(out_valid), 64'(1'b0));
        chk("reset_outputs", 64'({ovf, cout, sum}), 64'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'(1'b1));
        step();

        // Directed sums and boundaries.
        single("add_5_3",        32'h0000_0005, 32'h0000_0003, 1'b0, {1'b0, 1'b0, 32'h0000_0008});
        single("wrap_cin",       32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {1'b0, 1'b1, 32'h0000_0000});
        single("pos_overflow",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
        single("cin_only",       32'h0000_0000, 32'h0000_0000, 1'b1, {1'b0, 1'b0, 32'h0000_0001});
        single("neg_overflow",   32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 1'b1, 32'h0000_0000});
        single("neg_plus_neg1",  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {1'b1, 1'b1, 32'h7FFF_FFFF});
        single("mixed",          32'h1234_5678, 32'h8765_4321, 1'b0, {1'b0, 1'b0, 32'h9999_9999});
        single("alt_ripple",     32'hAAAA_AAAA, 32'h5555_5555, 1'b1, {1'b0, 1'b1, 32'h0000_0000});

        // Backpressure: only three beats fit, the output holds still.
        sent = 0; out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 32'h0000_0100 + 32'(sent); b = 32'hF000_0000; cin = 1'b1;
            cycle_io();
        end
        chk("bp_accepted", 64'(sent), 64'd3);
        chk("bp_in_ready_low", 64'(in_ready), 64'(1'b0));
        held = {ovf, cout, sum};
        cycle_io();
        cycle_io();
        chk("bp_output_stable", 64'({ovf, cout, sum}), 64'(held));
        chk("bp_out_valid", 64'(out_valid), 64'(1'b1));
        out_ready = 1'b1;
        a = 32'h0000_0100 + 32'(sent);
        #1;
        chk("full_accept_same_cycle", 64'(in_ready), 64'(1'b1));
        cycle_io();
        for (int i = 0; i < 20 && sent < 5; i++) begin
            a = 32'h0000_0100 + 32'(sent);
            cycle_io();
        end
        chk("bp_total_sent", 64'(sent), 64'd5);
        drain("bp_drain_empty");

        // Random back-to-back beats with toggling out_ready.
        sent = 0;
        for (int i = 0; i < 2000 && sent < 100; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1) == 1;
            a = $urandom(); b = $urandom(); cin = $urandom_range(0, 1) == 1;
            cycle_io();
        end
        chk("random_sent", 64'(sent), 64'd100);
        drain("random_drain_empty");

        // Flush with a full pipe; the concurrent beat is refused.
        sent = 0; out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom(); b = $urandom(); cin = 1'b0;
            cycle_io();
        end
        flush = 1'b1; a = 32'hDEAD_BEEF;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'(1'b0));
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'(1'b0));
        exp_q.delete();
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("flush_no_stale", 64'(seen), 64'd0);
        single("after_flush", 32'h0000_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b0, 32'h0001_0000});

        // Asynchronous reset in the middle of a stream.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = $urandom(); b = $urandom(); cin = 1'b1;
            cycle_io();
        end
        chk("ar_streaming", 64'(out_valid), 64'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("ar_async_drop", 64'(out_valid), 64'(1'b0));
        chk("ar_outputs_zero", 64'({ovf, cout, sum}), 64'd0);
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        exp_q.delete();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("ar_no_stale", 64'(seen), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'(1'b1));

        // 16-bit build, register after every level.
        single16("w16_wrap",     16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000});
        single16("w16_overflow", 16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000});
        single16("w16_cin",      16'h1234, 16'h4321, 1'b1, {1'b0, 1'b0, 16'h5556});
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom()); rb = 16'($urandom()); rc = $urandom_range(0, 1) == 1;
            single16("w16_random", ra, rb, rc, model16(ra, rb, rc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
